// File: rtl/cmd_frame_packer.sv
// Command-frame packer: wraps a streamed payload in sync/length/code header
// and an optional additive checksum trailer, writing into a TX FIFO port.
module cmd_frame_packer #(
  parameter int                     DW         = 8,
  parameter int                     CMD_W      = 5,
  parameter int                     N_CODES    = 5,
  parameter logic [N_CODES*DW-1:0]  CODE_TABLE = {8'h63, 8'h87, 8'h94, 8'h25, 8'h13},
  parameter logic [DW-1:0]          SYNC0      = 8'hEB,
  parameter logic [DW-1:0]          SYNC1      = 8'h90,
  parameter bit                     CHK_EN     = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             newcmd,
  input  logic [CMD_W-1:0] cmd,
  input  logic [DW-1:0]    length,
  input  logic             wen,
  input  logic [DW-1:0]    din,
  input  logic             rx_done,
  input  logic             full,
  output logic             valid,
  output logic [DW-1:0]    dout,
  output logic             busy,
  output logic             frame_done,
  output logic             drop_err,
  output logic             short_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HDR  = 2'd1;
  localparam logic [1:0] PAY  = 2'd2;
  localparam logic [1:0] CHK  = 2'd3;

  logic [1:0]    state_r, state_s;
  logic [1:0]    idx_r, idx_s;
  logic [DW-1:0] cnt_r, cnt_s;
  logic [DW-1:0] csum_r, csum_s;
  logic [DW-1:0] len_r, len_s;
  logic [DW-1:0] code_r, code_s;
  logic [DW-1:0] dout_r, dout_s;
  logic          valid_r, valid_s;
  logic          done_r, done_s;
  logic          drop_r, drop_s;
  logic          short_r, short_s;
  logic          accept_s;
  logic [DW-1:0] cnt_acc_s;

  function automatic logic [DW-1:0] csum_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return a + b;
  endfunction

  // Out-of-range command indices fall back to the last table entry.
  function automatic logic [DW-1:0] code_lookup(input logic [CMD_W-1:0] c);
    int sel;
    sel = (int'(c) < N_CODES) ? int'(c) : N_CODES - 1;
    return CODE_TABLE[sel*DW +: DW];
  endfunction

  assign accept_s  = wen && !full;
  assign cnt_acc_s = cnt_r + {{(DW-1){1'b0}}, accept_s};

  // Next-state, emission and error-pulse decisions.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    cnt_s   = cnt_r;
    csum_s  = csum_r;
    len_s   = len_r;
    code_s  = code_r;
    dout_s  = dout_r;
    valid_s = 1'b0;
    done_s  = 1'b0;
    drop_s  = 1'b0;
    short_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (newcmd && !full) begin
          len_s   = length;
          code_s  = code_lookup(cmd);
          csum_s  = {DW{1'b0}};
          idx_s   = 2'd0;
          cnt_s   = {DW{1'b0}};
          state_s = HDR;
        end else begin
          state_s = IDLE;
        end
      end
      HDR: begin
        if (rx_done) begin
          state_s = IDLE;
        end else if (!full) begin
          valid_s = 1'b1;
          idx_s   = idx_r + 2'd1;
          case (idx_r)
            2'd0:    dout_s = SYNC0;
            2'd1:    dout_s = SYNC1;
            2'd2:    begin dout_s = len_r;  csum_s = csum_add(csum_r, len_r);  end
            default: begin dout_s = code_r; csum_s = csum_add(csum_r, code_r); end
          endcase
          if (idx_r == 2'd3) begin
            if (len_r != {DW{1'b0}}) begin
              state_s = PAY;
            end else if (CHK_EN) begin
              state_s = CHK;
            end else begin
              state_s = IDLE;
              done_s  = 1'b1;
            end
          end else begin
            state_s = HDR;
          end
        end else begin
          state_s = HDR;
        end
      end
      PAY: begin
        if (accept_s) begin
          valid_s = 1'b1;
          dout_s  = din;
          csum_s  = csum_add(csum_r, din);
        end else begin
          valid_s = 1'b0;
        end
        drop_s = wen && full;
        cnt_s  = cnt_acc_s;
        // A byte accepted alongside rx_done is counted before the short check.
        if ((cnt_acc_s == len_r) || rx_done) begin
          short_s = (cnt_acc_s != len_r);
          if (CHK_EN) begin
            state_s = CHK;
          end else begin
            state_s = IDLE;
            done_s  = 1'b1;
          end
        end else begin
          state_s = PAY;
        end
      end
      CHK: begin
        if (!full) begin
          valid_s = 1'b1;
          dout_s  = csum_r;
          done_s  = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = CHK;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and registered FIFO-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      idx_r   <= 2'd0;
      cnt_r   <= {DW{1'b0}};
      csum_r  <= {DW{1'b0}};
      len_r   <= {DW{1'b0}};
      code_r  <= {DW{1'b0}};
      dout_r  <= {DW{1'b0}};
      valid_r <= 1'b0;
      done_r  <= 1'b0;
      drop_r  <= 1'b0;
      short_r <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      cnt_r   <= cnt_s;
      csum_r  <= csum_s;
      len_r   <= len_s;
      code_r  <= code_s;
      dout_r  <= dout_s;
      valid_r <= valid_s;
      done_r  <= done_s;
      drop_r  <= drop_s;
      short_r <= short_s;
    end
  end

  assign valid      = valid_r;
  assign dout       = dout_r;
  assign busy       = (state_r != IDLE);
  assign frame_done = done_r;
  assign drop_err   = drop_r;
  assign short_err  = short_r;

endmodule

// File: tb/tb_cmd_frame_packer.sv
// Directed bench for cmd_frame_packer with an expected-byte scoreboard.
module tb_cmd_frame_packer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       newcmd = 1'b0;
  logic [4:0] cmd = 5'd0;
  logic [7:0] length = 8'd0;
  logic       wen = 1'b0;
  logic [7:0] din = 8'd0;
  logic       rx_done = 1'b0;
  logic       full = 1'b0;
  logic       valid;
  logic [7:0] dout;
  logic       busy;
  logic       frame_done;
  logic       drop_err;
  logic       short_err;

  int checks = 0;
  int failures = 0;
  int drop_cnt = 0;
  int short_cnt = 0;
  int done_cnt = 0;
  logic [8:0] exp_q[$];

  cmd_frame_packer dut (
    .clk(clk), .rst_n(rst_n), .newcmd(newcmd), .cmd(cmd), .length(length),
    .wen(wen), .din(din), .rx_done(rx_done), .full(full), .valid(valid),
    .dout(dout), .busy(busy), .frame_done(frame_done), .drop_err(drop_err),
    .short_err(short_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input logic d);
    exp_q.push_back({d, b});
  endtask

  task automatic start(input logic [4:0] c, input logic [7:0] l);
    cmd = c; length = l; newcmd = 1'b1;
    tick();
    newcmd = 1'b0;
  endtask

  task automatic pay(input logic [7:0] b);
    wen = 1'b1; din = b;
    tick();
    wen = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0 && !busy) break;
      tick();
    end
    chk(tag, exp_q.size(), 0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  // Scoreboard: every written byte must match the head of the expected queue.
  always @(negedge clk) begin
    if (drop_err) drop_cnt++;
    if (short_err) short_cnt++;
    if (frame_done) done_cnt++;
    if (valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_byte", {23'd0, frame_done, dout}, 32'h1ff);
      end else begin
        chk("byte", {23'd0, frame_done, dout}, {23'd0, exp_q.pop_front()});
      end
    end else if (frame_done) begin
      chk("done_without_valid", frame_done, 1'b0);
    end
  end

  initial begin
    #12;
    chk("rst_valid", valid, 1'b0);
    chk("rst_dout", dout, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pulses", {frame_done, drop_err, short_err}, 3'b000);
    rst_n = 1'b1;
    tick();

    // newcmd while full is dropped, not queued
    full = 1'b1; newcmd = 1'b1;
    tick();
    newcmd = 1'b0; full = 1'b0;
    chk("newcmd_full_ignored", busy, 1'b0);
    tick();
    chk("newcmd_full_no_valid", valid, 1'b0);

    // Basic frame; newcmd held during header must be ignored
    push(8'hEB, 0); push(8'h90, 0); push(8'h03, 0); push(8'h94, 0);
    push(8'h01, 0); push(8'h02, 0); push(8'h03, 0); push(8'h9D, 1);
    start(5'd2, 8'd3);
    chk("basic_busy", busy, 1'b1);
    newcmd = 1'b1; cmd = 5'd0; length = 8'd7;
    repeat (4) tick();
    newcmd = 1'b0;
    pay(8'h01); pay(8'h02); pay(8'h03);
    drain("basic_drain");
    chk("basic_done_cnt", done_cnt, 1);

    // Out-of-range command, empty payload
    push(8'hEB, 0); push(8'h90, 0); push(8'h00, 0); push(8'h63, 0); push(8'h63, 1);
    start(5'd9, 8'd0);
    drain("empty_drain");
    chk("empty_done_cnt", done_cnt, 2);

    // Back-pressure during header after SYNC1
    push(8'hEB, 0); push(8'h90, 0); push(8'h03, 0); push(8'h13, 0);
    push(8'h10, 0); push(8'h20, 0); push(8'h30, 0); push(8'h76, 1);
    start(5'd0, 8'd3);
    repeat (2) tick();
    full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_no_valid", valid, 1'b0);
    end
    full = 1'b0;
    repeat (2) tick();
    pay(8'h10); pay(8'h20); pay(8'h30);
    drain("bp_drain");

    // Drop a payload byte under full
    push(8'hEB, 0); push(8'h90, 0); push(8'h02, 0); push(8'h25, 0);
    push(8'h11, 0); push(8'h22, 0); push(8'h5A, 1);
    start(5'd1, 8'd2);
    repeat (4) tick();
    full = 1'b1;
    pay(8'hAA);
    full = 1'b0;
    chk("drop_pulse", drop_err, 1'b1);
    chk("drop_no_valid", valid, 1'b0);
    pay(8'h11); pay(8'h22);
    drain("drop_drain");
    chk("drop_cnt", drop_cnt, 1);

    // Short payload: 2 of 4 bytes then rx_done
    push(8'hEB, 0); push(8'h90, 0); push(8'h04, 0); push(8'h87, 0);
    push(8'h05, 0); push(8'h06, 0); push(8'h96, 1);
    start(5'd3, 8'd4);
    repeat (4) tick();
    pay(8'h05); pay(8'h06);
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    chk("short_pulse", short_err, 1'b1);
    drain("short_drain");
    chk("short_cnt", short_cnt, 1);
    chk("short_done_cnt", done_cnt, 5);

    // Abort in header
    push(8'hEB, 0); push(8'h90, 0);
    start(5'd2, 8'd3);
    repeat (2) tick();
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    chk("abort_idle", busy, 1'b0);
    drain("abort_drain");
    chk("abort_done_cnt", done_cnt, 5);
    chk("abort_short_cnt", short_cnt, 1);

    // Reset mid-payload
    push(8'hEB, 0); push(8'h90, 0); push(8'h03, 0); push(8'h63, 0); push(8'h01, 0);
    start(5'd4, 8'd3);
    repeat (4) tick();
    pay(8'h01);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", valid, 1'b0);
    chk("rst_mid_dout", dout, 8'h00);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_pulses", {frame_done, drop_err, short_err}, 3'b000);
    chk("rst_mid_queue", exp_q.size(), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Clean frame after reset
    push(8'hEB, 0); push(8'h90, 0); push(8'h03, 0); push(8'h94, 0);
    push(8'h01, 0); push(8'h02, 0); push(8'h03, 0); push(8'h9D, 1);
    start(5'd2, 8'd3);
    repeat (4) tick();
    pay(8'h01); pay(8'h02); pay(8'h03);
    drain("post_rst_drain");
    chk("final_done_cnt", done_cnt, 6);
    chk("final_drop_cnt", drop_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
